// File: rtl/dmem_bus_bridge.sv
// Data-side bridge from the CPU port to N memory-mapped regions.
// Decodes the region, builds byte lanes, inserts wait states and reports faults.
module dmem_bus_bridge #(
    parameter int unsigned               N_REGION    = 2,
    parameter logic [N_REGION*32-1:0]    REGION_BASE = {32'h10020000, 32'h10010000},
    parameter int unsigned               REGION_AW   = 11,
    parameter int unsigned               WAIT_STATES = 0
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [1:0]               cpu_size,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic                     cpu_busy,
    output logic                     cpu_ack,
    output logic                     cpu_err,
    output logic [31:0]              cpu_rdata,
    output logic [N_REGION-1:0]      mem_sel,
    output logic                     mem_we,
    output logic [3:0]               mem_be,
    output logic [REGION_AW-3:0]     mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [N_REGION*32-1:0]   mem_rdata
);

    localparam logic [31:0] REGION_SIZE = 32'd1 << REGION_AW;
    localparam logic [3:0]  WAIT_CNT    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [1:0]            r_lane;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [REGION_AW-3:0]  r_addr;
    logic [N_REGION-1:0]   r_sel;
    logic                  r_err;
    logic [3:0]            r_cnt;
    logic [31:0]           r_rdata;

    logic [N_REGION-1:0]   w_hit_sel;
    logic [31:0]           w_offset;
    logic [31:0]           w_off_tmp;
    logic                  w_found;
    logic                  w_misalign;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rsel;
    logic [31:0]           w_rshift;
    logic [31:0]           w_rdata;
    logic                  w_access;

    // Lowest-index region whose modulo-2^32 offset falls inside the window wins.
    always_comb begin
        w_hit_sel = '0;
        w_offset  = '0;
        w_off_tmp = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < N_REGION; i++) begin
            w_off_tmp = cpu_addr - REGION_BASE[32*i +: 32];
            if (!w_found && (w_off_tmp < REGION_SIZE)) begin
                w_found      = 1'b1;
                w_hit_sel[i] = 1'b1;
                w_offset     = w_off_tmp;
            end
        end
    end

    always_comb begin
        w_misalign = ((cpu_size == 2'b01) && cpu_addr[0])
                  || ((cpu_size == 2'b10) && (cpu_addr[1:0] != 2'b00))
                  || (cpu_size == 2'b11);
        w_fault    = w_misalign || !w_found;
        case (cpu_size)
            2'b00: begin
                w_be    = 4'b0001 << cpu_addr[1:0];
                w_wdata = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << cpu_addr[1:0];
                w_wdata = {2{cpu_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = cpu_wdata;
            end
        endcase
    end

    // Read path: pick the selected region, move the addressed lane down, zero-extend.
    always_comb begin
        w_rsel = '0;
        for (int unsigned i = 0; i < N_REGION; i++) begin
            if (r_sel[i]) begin
                w_rsel = w_rsel | mem_rdata[32*i +: 32];
            end
        end
        w_rshift = w_rsel >> {r_lane, 3'b000};
        case (r_size)
            2'b00:   w_rdata = {24'd0, w_rshift[7:0]};
            2'b01:   w_rdata = {16'd0, w_rshift[15:0]};
            default: w_rdata = w_rshift;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_lane  <= 2'b00;
            r_wdata <= '0;
            r_be    <= '0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_size  <= cpu_size;
                        r_lane  <= cpu_addr[1:0];
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_addr  <= w_offset[REGION_AW-1:2];
                        r_err   <= w_fault;
                        r_rdata <= '0;
                        if (w_fault) begin
                            r_sel   <= '0;
                            r_state <= StResp;
                        end else begin
                            r_sel   <= w_hit_sel;
                            r_cnt   <= WAIT_CNT;
                            r_state <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= r_we ? 32'd0 : w_rdata;
                        r_sel   <= '0;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Memory-side outputs are gated by state so reset or a fault leaves them idle at once.
    assign w_access  = (r_state == StAccess);
    assign mem_sel   = w_access ? r_sel : '0;
    assign mem_be    = w_access ? r_be : 4'b0000;
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_wdata = w_access ? r_wdata : 32'd0;
    assign mem_we    = w_access && r_we && (r_cnt == 4'd0);

    assign cpu_busy  = (r_state != StIdle);
    assign cpu_ack   = (r_state == StResp);
    assign cpu_err   = (r_state == StResp) && r_err;
    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: one instance with no wait states, one with three.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        busy0, ack0, err0, mwe0;
    logic [31:0] rdata0, mwd0;
    logic [1:0]  sel0;
    logic [3:0]  be0;
    logic [8:0]  maddr0;
    logic [63:0] mrd0;

    logic        busy1, ack1, err1, mwe1;
    logic [31:0] rdata1, mwd1;
    logic [1:0]  sel1;
    logic [3:0]  be1;
    logic [8:0]  maddr1;
    logic [63:0] mrd1;

    logic [31:0] mem0 [2][512];
    logic [31:0] mem1 [2][512];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.WAIT_STATES(0)) u_dut0 (
        .clk_in(clk), .reset(rst_n), .cpu_req(req), .cpu_we(we), .cpu_size(size),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_busy(busy0), .cpu_ack(ack0),
        .cpu_err(err0), .cpu_rdata(rdata0), .mem_sel(sel0), .mem_we(mwe0), .mem_be(be0),
        .mem_addr(maddr0), .mem_wdata(mwd0), .mem_rdata(mrd0)
    );

    dmem_bus_bridge #(.WAIT_STATES(3)) u_dut1 (
        .clk_in(clk), .reset(rst_n), .cpu_req(req), .cpu_we(we), .cpu_size(size),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_busy(busy1), .cpu_ack(ack1),
        .cpu_err(err1), .cpu_rdata(rdata1), .mem_sel(sel1), .mem_we(mwe1), .mem_be(be1),
        .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    // Byte-enabled memory models, one per instance.
    always @(posedge clk) begin
        for (int r = 0; r < 2; r++)
            if (mwe0 && sel0[r])
                for (int k = 0; k < 4; k++)
                    if (be0[k]) mem0[r][maddr0][8*k +: 8] <= mwd0[8*k +: 8];
    end
    always @(posedge clk) begin
        for (int r = 0; r < 2; r++)
            if (mwe1 && sel1[r])
                for (int k = 0; k < 4; k++)
                    if (be1[k]) mem1[r][maddr1][8*k +: 8] <= mwd1[8*k +: 8];
    end
    assign mrd0 = {mem0[1][maddr0], mem0[0][maddr0]};
    assign mrd1 = {mem1[1][maddr1], mem1[0][maddr1]};

    logic        dsel;
    logic        o_ack, o_err, o_mwe, o_busy;
    logic [31:0] o_rdat, o_mwd;
    logic [1:0]  o_sel;
    logic [3:0]  o_be;
    logic [8:0]  o_maddr;

    always_comb begin
        o_ack   = dsel ? ack1   : ack0;
        o_err   = dsel ? err1   : err0;
        o_mwe   = dsel ? mwe1   : mwe0;
        o_busy  = dsel ? busy1  : busy0;
        o_rdat  = dsel ? rdata1 : rdata0;
        o_mwd   = dsel ? mwd1   : mwd0;
        o_sel   = dsel ? sel1   : sel0;
        o_be    = dsel ? be1    : be0;
        o_maddr = dsel ? maddr1 : maddr0;
    end

    int          lat, acc_cycles, we_pulses;
    logic        got_ack, addr_stable, r_err;
    logic [31:0] r_rdata, f_wd;
    logic [1:0]  f_sel;
    logic [3:0]  f_be;
    logic [8:0]  f_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one access, record what the memory side saw and when the ack arrived.
    task automatic run_acc(input logic d, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input bit poke);
        dsel = d;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
        got_ack = 1'b0; lat = 0; acc_cycles = 0; we_pulses = 0; addr_stable = 1'b1;
        r_err = 1'b0; r_rdata = '0; f_sel = '0; f_be = '0; f_addr = '0; f_wd = '0;
        @(negedge clk);
        req = 1'b0;
        for (int i = 1; i <= 12 && !got_ack; i++) begin
            if (o_ack) begin
                got_ack = 1'b1;
                lat     = i;
                r_err   = o_err;
                r_rdata = o_rdat;
            end else begin
                if (o_sel != 2'b00) begin
                    if (acc_cycles == 0) begin
                        f_sel = o_sel; f_addr = o_maddr; f_be = o_be; f_wd = o_mwd;
                    end else if (o_sel != f_sel || o_maddr != f_addr || o_be != f_be) begin
                        addr_stable = 1'b0;
                    end
                    acc_cycles++;
                end
                if (o_mwe) we_pulses++;
                if (poke && i == 2) begin
                    req = 1'b1; we = 1'b1; addr = 32'h10020020; wdata = 32'hFFFFFFFF;
                end
                if (poke && i == 3) req = 1'b0;
                @(negedge clk);
            end
        end
        if (!got_ack) check_eq("ack_timeout", 32'd0, 32'd1);
    endtask

    logic [1:0]  flt_size [4];
    logic [31:0] flt_addr [4];
    logic        flt_we   [4];
    logic        bad;

    initial begin
        dsel = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        rst_n = 1'b0;
        flt_we   = '{1'b0, 1'b1, 1'b0, 1'b0};
        flt_size = '{2'b10, 2'b01, 2'b11, 2'b10};
        flt_addr = '{32'h10010002, 32'h10010001, 32'h10010000, 32'h00400000};

        repeat (2) @(negedge clk);
        check_eq("rst_ctrl0", 32'({busy0, ack0, err0, mwe0, be0, sel0}), 32'd0);
        check_eq("rst_rdata0", rdata0, 32'd0);
        check_eq("rst_mem0", 32'({maddr0, mwd0 != 32'd0}), 32'd0);
        check_eq("rst_ctrl1", 32'({busy1, ack1, err1, mwe1, be1, sel1}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_acc(1'b0, 1'b1, 2'b10, 32'h10010000, 32'h11223344, 1'b0);
        check_eq("pre_lat", 32'(lat), 32'd2);

        run_acc(1'b0, 1'b1, 2'b10, 32'h10010008, 32'hDEADBEEF, 1'b0);
        check_eq("sw_sel", 32'(f_sel), 32'd1);
        check_eq("sw_addr", 32'(f_addr), 32'd2);
        check_eq("sw_be", 32'(f_be), 32'hF);
        check_eq("sw_wdata", f_wd, 32'hDEADBEEF);
        check_eq("sw_pulses", 32'(we_pulses), 32'd1);
        check_eq("sw_ack", 32'({r_err, r_rdata != 0, 6'(lat)}), 32'd2);

        run_acc(1'b0, 1'b0, 2'b10, 32'h10010008, 32'h0, 1'b0);
        check_eq("lw_rdata", r_rdata, 32'hDEADBEEF);
        check_eq("lw_lat", 32'(lat), 32'd2);
        check_eq("lw_err", 32'(r_err), 32'd0);
        check_eq("lw_nowe", 32'(we_pulses), 32'd0);

        run_acc(1'b0, 1'b1, 2'b00, 32'h10010003, 32'h000000A5, 1'b0);
        check_eq("sb_be", 32'(f_be), 32'b1000);
        check_eq("sb_wdata", f_wd, 32'hA5A5A5A5);
        check_eq("sb_pulses", 32'(we_pulses), 32'd1);

        run_acc(1'b0, 1'b0, 2'b01, 32'h10010002, 32'h0, 1'b0);
        check_eq("lh_be", 32'(f_be), 32'b1100);
        check_eq("lh_rdata", r_rdata, 32'h0000A522);

        run_acc(1'b0, 1'b0, 2'b00, 32'h10010001, 32'h0, 1'b0);
        check_eq("lb_rdata", r_rdata, 32'h00000033);

        for (int f = 0; f < 4; f++) begin
            run_acc(1'b0, flt_we[f], flt_size[f], flt_addr[f], 32'h5A5A5A5A, 1'b0);
            check_eq($sformatf("flt%0d_lat", f), 32'(lat), 32'd1);
            check_eq($sformatf("flt%0d_err", f), 32'(r_err), 32'd1);
            check_eq($sformatf("flt%0d_rdata", f), r_rdata, 32'd0);
            check_eq($sformatf("flt%0d_mem", f), 32'(acc_cycles + we_pulses), 32'd0);
        end

        run_acc(1'b0, 1'b1, 2'b10, 32'h100107FC, 32'hCAFEF00D, 1'b0);
        check_eq("top_addr", 32'(f_addr), 32'd511);
        check_eq("top_sel", 32'(f_sel), 32'd1);
        run_acc(1'b0, 1'b0, 2'b10, 32'h100107FC, 32'h0, 1'b0);
        check_eq("top_rdata", r_rdata, 32'hCAFEF00D);
        run_acc(1'b0, 1'b0, 2'b10, 32'h10010800, 32'h0, 1'b0);
        check_eq("past_err", 32'({r_err, 6'(lat)}), 32'h41);

        dsel = 1'b1;
        repeat (8) @(negedge clk);
        run_acc(1'b1, 1'b1, 2'b10, 32'h10020010, 32'h12345678, 1'b0);
        check_eq("ws3_sw_lat", 32'(lat), 32'd5);
        run_acc(1'b1, 1'b0, 2'b10, 32'h10020010, 32'h0, 1'b1);
        check_eq("ws3_sel", 32'(f_sel), 32'd2);
        check_eq("ws3_cycles", 32'(acc_cycles), 32'd4);
        check_eq("ws3_addr", 32'(f_addr), 32'd4);
        check_eq("ws3_stable", 32'(addr_stable), 32'd1);
        check_eq("ws3_lat", 32'(lat), 32'd5);
        check_eq("ws3_rdata", r_rdata, 32'h12345678);
        check_eq("ws3_nowe", 32'(we_pulses), 32'd0);
        @(negedge clk);
        check_eq("ws3_idle", 32'(busy1), 32'd0);

        // Reset in the second wait-state cycle of a write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10020010; wdata = 32'h55AA55AA;
        @(negedge clk);
        req = 1'b0;
        check_eq("mid_sel_pre", 32'(sel1), 32'd2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_clear", 32'({busy1, mwe1, be1, sel1}), 32'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack1 || mwe1) bad = 1'b1;
        end
        check_eq("mid_noack", 32'(bad), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_acc(1'b1, 1'b0, 2'b10, 32'h10020010, 32'h0, 1'b0);
        check_eq("post_rdata", r_rdata, 32'h12345678);
        check_eq("post_lat", 32'({r_err, 6'(lat)}), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Parametrised data-side bus bridge between the CPU data port and N memory-mapped regions of the single-cycle system. It decodes each CPU access against per-region base addresses, subtracts the base, converts byte/half/word size into byte enables and lane-aligned data, and inserts a programmable number of wait states with a busy/ack handshake. Faults for unmapped, misaligned or reserved-size accesses are reported instead of reaching memory.

## Interface
- N_REGION, 2, number of downstream regions (1..8)
- REGION_BASE, {32'h10020000, 32'h10010000}, packed N_REGION×32 base addresses; region i at bits [32i+31:32i]
- REGION_AW, 11, log2 of region size in bytes; every region is 2^REGION_AW bytes
- WAIT_STATES, 0, extra access cycles per access (0..15)

- clk_in  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cpu_req  in  1  access request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data, right-justified
- cpu_busy  out  1  high whenever state ≠ IDLE
- cpu_ack  out  1  one-cycle pulse: access complete
- cpu_err  out  1  valid with cpu_ack; 1 = fault, no memory effect
- cpu_rdata  out  32  read data, right-justified, zero-extended; valid with cpu_ack
- mem_sel  out  N_REGION  one-hot region select
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables, bit k = byte lane k (little-endian)
- mem_addr  out  REGION_AW-2  word index within region
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  N_REGION×32  per-region combinational read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, cpu_req=1: register we, size, wdata, offset, region, fault; fault → RESP, else → ACCESS with wait counter = WAIT_STATES.
- Decode: offset_i = cpu_addr − base_i (32-bit, modulo); hit_i = offset_i < 2^REGION_AW. Lowest-index hit wins. No hit → fault.
- Alignment: half requires addr[0]=0, word requires addr[1:0]=00; violation or size=11 → fault. Faults take priority over the decode result and leave mem_* outputs idle.
- Byte enables: byte → 1 << addr[1:0]; half → 0011 << addr[1:0]; word → 1111.
- mem_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- ACCESS: mem_sel, mem_addr = offset[REGION_AW-1:2], and mem_be are held stable for WAIT_STATES+1 cycles. The counter decrements each cycle. mem_we is high only in the final ACCESS cycle (counter = 0), so exactly one write strobe is issued per access. In the final cycle, rdata of the selected region is captured, shifted right by 8×addr[1:0], and masked to size. → RESP.
- RESP: cpu_ack=1 for one cycle; cpu_err is 1 for faults; cpu_rdata is the captured value, or 0 on fault or write. → IDLE.
- cpu_req while busy is ignored; the CPU must hold or re-issue it. A request in the same cycle as the return to IDLE is not accepted until the next cycle.

## Timing
- Reset (async assert, sync release): state IDLE, cpu_busy/ack/err=0, cpu_rdata=0, mem_sel=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0.
- All outputs are registered or decoded from state only; there is no combinational path from cpu_* to any output.
- Valid access: request sampled at edge 0; ACCESS in cycles 1..WAIT_STATES+1; cpu_ack in cycle WAIT_STATES+2.
- Fault: request sampled at edge 0; cpu_ack with cpu_err in cycle 1; mem_sel stays 0.
- Throughput: one access per WAIT_STATES+3 cycles, because IDLE takes one cycle between accesses.
- Reset asserted mid-ACCESS: mem_we and mem_sel drop immediately, no ack is issued, and no partial write strobe is issued.
- Offset arithmetic wraps modulo 2^32. An address below the base gives a large offset and is unmapped.

## Test plan
- Word write then read, WAIT_STATES=0: write 0xDEADBEEF to 0x10010008, then read 0x10010008. Required: mem_sel=01, mem_addr=2, mem_be=1111, one mem_we pulse; read acks 2 cycles after the request with rdata=0xDEADBEEF and err=0.
- Sub-word lanes: sb 0xA5 to 0x10010003, then lh from 0x10010002. Required: mem_be=1000 with mem_wdata=0xA5A5A5A5; the half read returns 0x0000A5xx, right-justified and zero-extended.
- Region 1 with WAIT_STATES=3: read 0x10020010. Required: mem_sel=10 for 4 cycles, mem_addr=4, ack 5 cycles after the request, and any new req during busy is ignored.
- Faults: lw 0x10010002, sh 0x10010001, size=11, and address 0x00400000. Each must produce ack+err 1 cycle after the request, rdata=0, mem_sel=0 and mem_we never asserted.
- Boundary: word at 0x100107FC maps to region 0 with mem_addr=511; a word at 0x10010800 is unmapped → err.
- Async reset: drop reset in the 2nd ACCESS cycle with WAIT_STATES=3. Outputs must clear the same cycle, no mem_we pulse and no ack; after release, a fresh request completes normally.
